// File: rtl/spi_burst_deserializer.sv
// spi_burst_deserializer: SPI target front end decoding R/W + address + data-word frames
// (optionally bursting with address auto-increment) into one-cycle register-file strobes.
module spi_burst_deserializer #(
  parameter int CDC_LEN = 2,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8,
  parameter bit CPOL    = 1'b0,
  parameter bit CPHA    = 1'b0,
  parameter bit BURST   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              copi,
  input  logic              n_cs,
  output logic              read_write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              frame_err
);
  localparam logic [5:0] A_LAST = 6'(ADDR_W);
  localparam logic [5:0] D_LAST = 6'(DATA_W - 1);
  typedef enum logic [1:0] {IDLE, HEADER, DATA, DRAIN} state_t;
  state_t state, state_nx;
  logic [CDC_LEN-1:0] sclk_sync, copi_sync, ncs_sync;
  logic sclk_d, rst_q, armed, sclk_s, copi_s, ncs_s;
  logic sample, hdr_done, word_done, frame_end, err, rw_q, got_word;
  logic [5:0] bit_cnt;
  logic [ADDR_W-1:0] addr_sr, word_addr, addr_nx;
  logic [DATA_W-1:0] data_sr, data_nx;
  logic [ADDR_W:0] addr_ext;
  logic [DATA_W:0] data_ext;
  assign sclk_s = sclk_sync[CDC_LEN-1];
  assign copi_s = copi_sync[CDC_LEN-1];
  assign ncs_s = ncs_sync[CDC_LEN-1];
  assign addr_ext = {addr_sr, copi_s};
  assign data_ext = {data_sr, copi_s};
  assign addr_nx = addr_ext[ADDR_W-1:0];
  assign data_nx = data_ext[DATA_W-1:0];
  assign sample = state != IDLE && ((CPOL ^ CPHA) ? (sclk_d && !sclk_s) : (!sclk_d && sclk_s));
  assign hdr_done = state == HEADER && sample && bit_cnt == A_LAST;
  assign word_done = state == DATA && sample && bit_cnt == D_LAST;
  assign frame_end = ncs_s && state != IDLE;
  assign err = frame_end && !word_done &&
               ((state == HEADER && (bit_cnt != '0 || sample)) ||
                (state == DATA && (bit_cnt != '0 || sample || !got_word)));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync <= {CDC_LEN{CPOL}};
      copi_sync <= '0;
      ncs_sync  <= '1;
      sclk_d    <= CPOL;
    end else begin
      sclk_sync <= {sclk_sync[CDC_LEN-2:0], sclk};
      copi_sync <= {copi_sync[CDC_LEN-2:0], copi};
      ncs_sync  <= {ncs_sync[CDC_LEN-2:0], n_cs};
      sclk_d    <= sclk_s;
    end
  end
  // A frame may only start after n_cs has been seen high since reset, so a frame cut by reset is skipped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rst_q <= 1'b1;
      armed <= 1'b0;
    end else begin
      rst_q <= 1'b0;
      armed <= !rst_q && (armed || ncs_sync[0]);
    end
  end
  always_comb begin
    state_nx = frame_end ? IDLE
             : (state == IDLE && armed && !ncs_s) ? HEADER
             : hdr_done ? DATA
             : (word_done && !BURST) ? DRAIN
             : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      read_write <= 1'b0;
      addr       <= '0;
      data       <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      rw_q       <= 1'b0;
      got_word   <= 1'b0;
      bit_cnt    <= '0;
      addr_sr    <= '0;
      word_addr  <= '0;
      data_sr    <= '0;
    end else begin
      valid     <= word_done;
      frame_err <= err;
      if (state == IDLE) begin
        bit_cnt  <= '0;
        got_word <= 1'b0;
      end
      if (sample && state == HEADER) begin
        if (bit_cnt == '0) rw_q <= copi_s;
        else addr_sr <= addr_nx;
        bit_cnt <= hdr_done ? 6'd0 : bit_cnt + 6'd1;
        if (hdr_done) word_addr <= addr_nx;
      end
      if (sample && state == DATA) begin
        data_sr <= data_nx;
        bit_cnt <= word_done ? 6'd0 : bit_cnt + 6'd1;
      end
      if (word_done) begin
        read_write <= rw_q;
        addr       <= word_addr;
        data       <= data_nx;
        word_addr  <= word_addr + 1'b1;
        got_word   <= 1'b1;
      end
      if (frame_end) begin
        bit_cnt  <= '0;
        got_word <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_spi_burst_deserializer.sv
// tb_spi_burst_deserializer: directed frame vectors across five DUT configurations
// (mode 0 burst/single, modes 1/2/3 with wide fields) plus a mid-frame reset sequence.
module tb_spi_burst_deserializer;
  localparam int H = 4;
  logic clk = 1'b0, rst_n = 1'b0, ph = 1'b0, copi = 1'b0;
  logic [4:0] ncs = '1;
  logic [4:0] v, fe;
  logic orw [5];
  logic [15:0] oa [5], od [5];
  logic [6:0] a0, a1;
  logic [7:0] d0, d1;
  logic [9:0] a2, a3, a4;
  logic [15:0] d2, d3, d4;
  always #5 clk = ~clk;

  spi_burst_deserializer u0 (.clk(clk), .rst_n(rst_n), .sclk(ph), .copi(copi), .n_cs(ncs[0]),
    .read_write(orw[0]), .addr(a0), .data(d0), .valid(v[0]), .frame_err(fe[0]));
  spi_burst_deserializer #(.BURST(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .sclk(ph), .copi(copi),
    .n_cs(ncs[1]), .read_write(orw[1]), .addr(a1), .data(d1), .valid(v[1]), .frame_err(fe[1]));
  spi_burst_deserializer #(.ADDR_W(10), .DATA_W(16), .CPOL(1'b0), .CPHA(1'b1)) u2 (.clk(clk),
    .rst_n(rst_n), .sclk(ph), .copi(copi), .n_cs(ncs[2]), .read_write(orw[2]), .addr(a2),
    .data(d2), .valid(v[2]), .frame_err(fe[2]));
  spi_burst_deserializer #(.ADDR_W(10), .DATA_W(16), .CPOL(1'b1), .CPHA(1'b0)) u3 (.clk(clk),
    .rst_n(rst_n), .sclk(~ph), .copi(copi), .n_cs(ncs[3]), .read_write(orw[3]), .addr(a3),
    .data(d3), .valid(v[3]), .frame_err(fe[3]));
  spi_burst_deserializer #(.ADDR_W(10), .DATA_W(16), .CPOL(1'b1), .CPHA(1'b1)) u4 (.clk(clk),
    .rst_n(rst_n), .sclk(~ph), .copi(copi), .n_cs(ncs[4]), .read_write(orw[4]), .addr(a4),
    .data(d4), .valid(v[4]), .frame_err(fe[4]));

  assign oa[0] = {9'b0, a0};
  assign oa[1] = {9'b0, a1};
  assign oa[2] = {6'b0, a2};
  assign oa[3] = {6'b0, a3};
  assign oa[4] = {6'b0, a4};
  assign od[0] = {8'b0, d0};
  assign od[1] = {8'b0, d1};
  assign od[2] = d2;
  assign od[3] = d3;
  assign od[4] = d4;

  typedef struct {int k; logic rw; logic [15:0] a; logic [15:0] d;} ev_t;
  ev_t log_q[$];
  int errs [5];
  int both = 0;
  always @(negedge clk) begin
    for (int k = 0; k < 5; k++) begin
      if (v[k]) log_q.push_back('{k, orw[k], oa[k], od[k]});
      if (fe[k]) errs[k]++;
      if (v[k] && fe[k]) both++;
    end
  end

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int sel, input logic [63:0] bits, input int n, input bit cpha,
                      input bit close);
    ncs[sel] = 1'b0;
    clks(H);
    for (int i = n - 1; i >= 0; i--) begin
      if (!cpha) begin
        copi = bits[i];
        clks(H);
        ph = 1'b1;
        clks(H);
        ph = 1'b0;
      end else begin
        ph = 1'b1;
        copi = bits[i];
        clks(H);
        ph = 1'b0;
        clks(H);
      end
    end
    if (close) begin
      clks(H);
      ncs[sel] = 1'b1;
      clks(3 * H);
    end
  endtask

  typedef struct {
    int sel; int n; logic [63:0] bits; bit cpha;
    int nv; logic rw; logic [15:0] af, df, am, dm, al, dl; int ne;
  } vec_t;
  vec_t vecs [9];
  logic exp_rw [5];
  logic [15:0] exp_a [5], exp_d [5];

  initial begin
    vecs[0] = '{0, 16, {1'b1, 7'h25, 8'hA5}, 1'b0, 1, 1'b1, 16'h25, 16'hA5, 16'h25, 16'hA5, 16'h25, 16'hA5, 0};
    vecs[1] = '{0, 5, 64'b10110, 1'b0, 0, 1'b0, 0, 0, 0, 0, 0, 0, 1};
    vecs[2] = '{0, 11, {1'b0, 7'h01, 3'b101}, 1'b0, 0, 1'b0, 0, 0, 0, 0, 0, 0, 1};
    vecs[3] = '{0, 8, {1'b0, 7'h44}, 1'b0, 0, 1'b0, 0, 0, 0, 0, 0, 0, 1};
    vecs[4] = '{0, 32, {1'b0, 7'h7E, 8'h11, 8'h22, 8'h33}, 1'b0, 3, 1'b0,
                16'h7E, 16'h11, 16'h7F, 16'h22, 16'h00, 16'h33, 0};
    vecs[5] = '{1, 32, {1'b1, 7'h10, 8'h5A, 8'hC3, 8'h3C}, 1'b0, 1, 1'b1,
                16'h10, 16'h5A, 16'h10, 16'h5A, 16'h10, 16'h5A, 0};
    for (int m = 0; m < 3; m++)
      vecs[6+m] = '{2 + m, 27, {1'b1, 10'h2C3, 16'hBEEF}, m != 1, 1, 1'b1,
                    16'h2C3, 16'hBEEF, 16'h2C3, 16'hBEEF, 16'h2C3, 16'hBEEF, 0};
    for (int k = 0; k < 5; k++) begin
      exp_rw[k] = 1'b0;
      exp_a[k] = '0;
      exp_d[k] = '0;
      errs[k] = 0;
    end
    clks(4);
    rst_n = 1'b1;
    clks(4);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("reset_addr[%0d]", k), oa[k], 0);
      chk($sformatf("reset_data[%0d]", k), od[k], 0);
    end
    chk("reset_rw0", orw[0], 0);
    chk("reset_strobes", {v, fe}, 0);

    for (int i = 0; i < 9; i++) begin
      automatic vec_t t = vecs[i];
      automatic int q0 = log_q.size();
      automatic int e0 = errs[t.sel];
      automatic int nv;
      automatic ev_t f, m, l;
      send(t.sel, t.bits, t.n, t.cpha, 1'b1);
      nv = log_q.size() - q0;
      chk($sformatf("v%0d_valid_count", i), nv, t.nv);
      chk($sformatf("v%0d_frame_err_count", i), errs[t.sel] - e0, t.ne);
      if (t.nv > 0) begin
        f = nv > 0 ? log_q[q0] : '{-1, 1'bx, 'x, 'x};
        m = nv > 1 ? log_q[q0+1] : f;
        l = nv > 0 ? log_q[q0+nv-1] : f;
        chk($sformatf("v%0d_dut", i), f.k, t.sel);
        chk($sformatf("v%0d_rw", i), f.rw, t.rw);
        chk($sformatf("v%0d_first_addr", i), f.a, t.af);
        chk($sformatf("v%0d_first_data", i), f.d, t.df);
        if (t.nv > 1) chk($sformatf("v%0d_mid_addr_data", i), {m.a, m.d}, {t.am, t.dm});
        chk($sformatf("v%0d_last_addr_data", i), {l.a, l.d}, {t.al, t.dl});
        exp_rw[t.sel] = t.rw;
        exp_a[t.sel] = t.al;
        exp_d[t.sel] = t.dl;
      end
      chk($sformatf("v%0d_hold_rw", i), orw[t.sel], exp_rw[t.sel]);
      chk($sformatf("v%0d_hold_addr", i), oa[t.sel], exp_a[t.sel]);
      chk($sformatf("v%0d_hold_data", i), od[t.sel], exp_d[t.sel]);
    end

    begin
      automatic int q0 = log_q.size();
      automatic int e0 = errs[2];
      send(2, {1'b0, 10'h155, 4'b1010}, 15, 1'b1, 1'b0);
      rst_n = 1'b0;
      clks(1);
      rst_n = 1'b1;
      clks(1);
      chk("rst_mid_outputs", {orw[2], oa[2], od[2]}, 0);
      send(2, 64'hFFF, 12, 1'b1, 1'b1);
      chk("rst_mid_no_valid", log_q.size() - q0, 0);
      chk("rst_mid_no_err", errs[2] - e0, 0);
      chk("rst_mid_outputs_held", {orw[2], oa[2], od[2]}, 0);
      send(2, {1'b1, 10'h3A5, 16'h1234}, 27, 1'b1, 1'b1);
      chk("post_rst_valid_count", log_q.size() - q0, 1);
      chk("post_rst_err", errs[2] - e0, 0);
      chk("post_rst_decode", {orw[2], oa[2], od[2]}, {1'b1, 16'h3A5, 16'h1234});
    end
    chk("valid_err_overlap", both, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
